// File: rtl/ula_raster_gen.sv
// rtl/ula_raster_gen.sv - programmable ZX-style raster/timing generator with per-profile timing registers
// Optional line interrupt (lint_en, lint_line, nLINT) is built when ULA_RASTER_LINE_INT_EN is defined.
module ula_raster_gen #(
    parameter int HC_W    = 9,
    parameter int VC_W    = 9,
    parameter int NPROF   = 4,
    parameter int FLASH_W = 5,
    localparam int PW     = $clog2(NPROF),
    localparam int CW     = (HC_W > VC_W) ? HC_W : VC_W
) (
    input  logic               clk_sys,
    input  logic               nRESET,
    input  logic               ce_pix,
    input  logic [PW-1:0]      prof_sel,
    input  logic               cfg_wr,
    input  logic [PW-1:0]      cfg_prof,
    input  logic [3:0]         cfg_field,
    input  logic [CW-1:0]      cfg_data,
    output logic [HC_W-1:0]    hc,
    output logic [VC_W-1:0]    vc,
    output logic               Border,
    output logic               HBlank,
    output logic               HSync,
    output logic               VSync,
    output logic               nINT,
    output logic [FLASH_W-1:0] FlashCnt,
    output logic               frame_start,
    output logic [PW-1:0]      active_prof
`ifdef ULA_RASTER_LINE_INT_EN
    ,
    input  logic               lint_en,
    input  logic [VC_W-1:0]    lint_line,
    output logic               nLINT
`endif
);

    localparam int F_HTOTAL  = 0;
    localparam int F_VTOTAL  = 1;
    localparam int F_HBL_S   = 2;
    localparam int F_HBL_E   = 3;
    localparam int F_HS_S    = 4;
    localparam int F_HS_E    = 5;
    localparam int F_VS_S    = 6;
    localparam int F_VS_E    = 7;
    localparam int F_INT_V   = 8;
    localparam int F_INT_H   = 9;
    localparam int F_INT_LEN = 10;
    localparam int NFIELD    = 11;

    localparam logic [HC_W-1:0]    H_ONE = HC_W'(1);
    localparam logic [VC_W-1:0]    V_ONE = VC_W'(1);
    localparam logic [CW-1:0]      C_ONE = CW'(1);
    localparam logic [FLASH_W-1:0] F_ONE = FLASH_W'(1);

    // Power-on timing for P0 ZX48, P1 ZX128, P2 Pentagon; higher profiles mirror ZX48.
    function automatic logic [CW-1:0] dflt(input int p, input int f);
        int v;
        case (f)
            F_HTOTAL:  v = (p == 1) ? 456 : 448;
            F_VTOTAL:  v = (p == 1) ? 311 : (p == 2) ? 320 : 312;
            F_HBL_S:   v = 312;
            F_HBL_E:   v = (p == 1) ? 424 : (p == 2) ? 420 : 416;
            F_HS_S:    v = (p == 1) ? 340 : (p == 2) ? 338 : 336;
            F_HS_E:    v = (p == 1) ? 372 : (p == 2) ? 370 : 368;
            F_VS_S:    v = (p == 2) ? 248 : 240;
            F_VS_E:    v = (p == 2) ? 256 : 244;
            F_INT_V:   v = (p == 1) ? 248 : (p == 2) ? 239 : 248;
            F_INT_H:   v = (p == 1) ? 8 : (p == 2) ? 324 : 4;
            F_INT_LEN: v = (p == 1) ? 72 : 64;
            default:   v = 0;
        endcase
        return CW'(v);
    endfunction

    // End has priority so a window with start==end never opens.
    function automatic logic win(input logic cur, input logic hit_s, input logic hit_e);
        return hit_e ? 1'b0 : (hit_s ? 1'b1 : cur);
    endfunction

    logic [CW-1:0] prof_r [NPROF][NFIELD];
    logic [CW-1:0] int_cnt;

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            for (int p = 0; p < NPROF; p++)
                for (int f = 0; f < NFIELD; f++)
                    prof_r[p][f] <= dflt(p, f);
        end else if (cfg_wr && cfg_field <= 4'd10 && 32'(cfg_prof) < NPROF) begin
            prof_r[cfg_prof][cfg_field] <= cfg_data;
        end
    end

    logic [HC_W-1:0] htot_m1, hc_nx;
    logic [VC_W-1:0] vtot_m1, vc_nx;
    logic            h_wrap, v_wrap, f_wrap;
    logic            int_hit;
    logic [CW-1:0]   int_len;

    always_comb begin
        htot_m1 = prof_r[active_prof][F_HTOTAL][HC_W-1:0] - H_ONE;
        vtot_m1 = prof_r[active_prof][F_VTOTAL][VC_W-1:0] - V_ONE;
        h_wrap  = (hc >= htot_m1);
        v_wrap  = (vc >= vtot_m1);
        f_wrap  = h_wrap && v_wrap;
        hc_nx   = h_wrap ? '0 : hc + H_ONE;
        vc_nx   = vc;
        if (h_wrap)
            vc_nx = v_wrap ? '0 : vc + V_ONE;
        int_len = prof_r[active_prof][F_INT_LEN];
        int_hit = (vc_nx == prof_r[active_prof][F_INT_V][VC_W-1:0]) &&
                  (hc_nx == prof_r[active_prof][F_INT_H][HC_W-1:0]);
    end

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            hc          <= '0;
            vc          <= '0;
            Border      <= 1'b0;
            HBlank      <= 1'b0;
            HSync       <= 1'b0;
            VSync       <= 1'b0;
            nINT        <= 1'b1;
            int_cnt     <= '0;
            FlashCnt    <= '0;
            frame_start <= 1'b0;
            active_prof <= '0;
        end else begin
            frame_start <= 1'b0;
            if (ce_pix) begin
                hc     <= hc_nx;
                vc     <= vc_nx;
                Border <= (32'(vc_nx) >= 192) || (32'(hc_nx) >= 256);
                HBlank <= win(HBlank, hc_nx == prof_r[active_prof][F_HBL_S][HC_W-1:0],
                                      hc_nx == prof_r[active_prof][F_HBL_E][HC_W-1:0]);
                HSync  <= win(HSync,  hc_nx == prof_r[active_prof][F_HS_S][HC_W-1:0],
                                      hc_nx == prof_r[active_prof][F_HS_E][HC_W-1:0]);
                VSync  <= win(VSync,  vc_nx == prof_r[active_prof][F_VS_S][VC_W-1:0],
                                      vc_nx == prof_r[active_prof][F_VS_E][VC_W-1:0]);
                if (f_wrap) begin
                    FlashCnt    <= FlashCnt + F_ONE;
                    active_prof <= (32'(prof_sel) < NPROF) ? prof_sel : '0;
                    frame_start <= 1'b1;
                end
                // While low, matches are ignored: the pulse is never retriggered or stretched.
                if (!nINT) begin
                    if (int_cnt <= C_ONE) begin
                        int_cnt <= '0;
                        nINT    <= 1'b1;
                    end else begin
                        int_cnt <= int_cnt - C_ONE;
                    end
                end else if (int_hit && int_len != '0) begin
                    nINT    <= 1'b0;
                    int_cnt <= int_len;
                end
            end
        end
    end

`ifdef ULA_RASTER_LINE_INT_EN
    // Sampled only at the line wrap, so mid-line lint_line changes wait for the next line.
    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET)
            nLINT <= 1'b1;
        else if (ce_pix && h_wrap)
            nLINT <= !(lint_en && vc_nx == lint_line);
    end
`endif

endmodule
